// File: rtl/param_serial_tx_pkg.sv
`timescale 1ns/1ps
// param_serial_tx_pkg
// Shared types and width helpers for the buffered serial transmitter.
//   tx_state_e    : transmitter FSM states (IDLE, LOAD, SHIFT, GAP)
//   level_width   : width of a FIFO occupancy count for a given depth
//   bitcnt_width  : width of the bit counter for a given word width
//   gapcnt_width  : width of the inter-word gap counter
package param_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Occupancy runs 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Counts bit positions 0..data_w-1.
  function automatic int bitcnt_width(input int data_w);
    return (data_w > 2) ? $clog2(data_w) : 1;
  endfunction

  // Counts gap cycles 0..gap-1; kept at least one bit wide so a zero gap
  // still yields a legal vector.
  function automatic int gapcnt_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/param_serial_tx_fifo.sv
`timescale 1ns/1ps
// sync_fifo
// Single-clock FIFO with registered full/empty/level flags.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push, din  : enqueue din unless full (a push while full is dropped,
//                even if a pop happens in the same cycle)
//   pop, dout  : dequeue the head; dout always shows the current head;
//                a pop while empty is ignored
//   full, empty, level : registered occupancy status
module sync_fifo
  import param_serial_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int LEVEL_W = level_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;
  logic [LEVEL_W-1:0] level_nxt;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LEVEL_W'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LEVEL_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Flags are
  // derived from the next occupancy so they are valid right after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LEVEL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/param_serial_tx.sv
`timescale 1ns/1ps
// param_serial_tx
// Buffered serial transmitter: result words are queued in a FIFO and shifted
// out one bit per bit period on DataOut, with a generated bit clock ClkTx.
//   Clk, Reset : system clock (rising edge), asynchronous active-low reset
//   DIn        : word to enqueue, or divider value when ConfigDiv=1
//   Push       : enqueue DIn (ignored when ConfigDiv=1)
//   ConfigDiv  : load DIn[DIV_W-1:0] into the divider (only while idle)
//   LsbFirst   : bit order for the next word (1 = LSB first)
//   Busy       : transmitter is not idle
//   DOutValid  : DataOut carries a valid bit
//   DataOut    : serial data, changes only at bit-period start
//   ClkTx      : bit clock, high for the first half of each bit period
//   Full, Empty, Level : FIFO status
module param_serial_tx
  import param_serial_tx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int DIV_W      = 8,
  parameter int DIV_RST    = 0,
  parameter int GAP_CYCLES = 2,
  localparam int LEVEL_W   = level_width(DEPTH)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  DIn,
  input  logic               Push,
  input  logic               ConfigDiv,
  input  logic               LsbFirst,
  output logic               Busy,
  output logic               DOutValid,
  output logic               DataOut,
  output logic               ClkTx,
  output logic               Full,
  output logic               Empty,
  output logic [LEVEL_W-1:0] Level
);

  localparam int BIT_W = bitcnt_width(DATA_W);
  localparam int PH_W  = DIV_W + 1;
  localparam int GAP_W = gapcnt_width(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_lat;
  logic              lsb_lat;
  logic [DATA_W-1:0] shreg;
  logic [PH_W-1:0]   phase;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              period_end;
  logic              last_bit;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset),
    .push  (Push && !ConfigDiv),
    .pop   (fifo_pop),
    .din   (DIn),
    .dout  (fifo_dout),
    .full  (Full),
    .empty (Empty),
    .level (Level)
  );

  // A bit period is 2*(div+1) cycles, so its last phase is 2*div+1. The
  // phase counter is one bit wider than the divider so the maximum divider
  // never wraps it.
  assign period_end = (phase == {div_lat, 1'b1});
  assign last_bit   = (bit_cnt == BIT_LAST);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and outputs. The FIFO head is popped during LOAD and
  // captured into the shift register at the end of that cycle.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    Busy      = (state != IDLE);
    DOutValid = (state == SHIFT);
    ClkTx     = (state == SHIFT) && (phase <= {1'b0, div_lat});
    DataOut   = (state == SHIFT) && (lsb_lat ? shreg[0] : shreg[DATA_W-1]);
    case (state)
      IDLE: begin
        if (!Empty) state_nxt = LOAD;
      end
      LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (period_end && last_bit) begin
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Divider register: writable only while idle, so a word in flight and
  // any word already committed by LOAD keep the divider they started with.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_reg <= DIV_W'(DIV_RST);
    end else if (ConfigDiv && (state == IDLE)) begin
      div_reg <= DIn[DIV_W-1:0];
    end
  end

  // Shift datapath. Bit order and divider are frozen at LOAD so changes
  // mid-word cannot disturb the word being sent.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_lat <= '0;
      lsb_lat <= 1'b0;
      shreg   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      case (state)
        LOAD: begin
          shreg   <= fifo_dout;
          lsb_lat <= LsbFirst;
          div_lat <= div_reg;
          phase   <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (period_end) begin
            phase <= '0;
            shreg <= lsb_lat ? (shreg >> 1) : (shreg << 1);
            if (!last_bit) bit_cnt <= bit_cnt + BIT_W'(1);
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
